// File: rtl/key_pkg.sv
// Shared key-handling definitions: classifier state encoding and the ms-to-cycles
// conversion, so the debouncer and the classifier agree on FREQ units.
package key_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPress1 = 3'd1,
        StWait2  = 3'd2,
        StPress2 = 3'd3,
        StHold   = 3'd4
    } key_state_e;

    // FREQ is in MHz, so one ms is FREQ*1000 cycles.
    function automatic int unsigned ms_to_cyc(input int unsigned ms, input int unsigned freq);
        return ms * 1000 * freq;
    endfunction

endpackage

// File: rtl/key_event_classifier_if.sv
// Key pulse inputs and classified event outputs of the key event classifier.
interface key_event_classifier_if;
    logic key_press;
    logic key_release;
    logic short_press;
    logic double_click;
    logic long_press;
    logic key_repeat;
    logic busy;

    modport master (
        output key_press, key_release,
        input  short_press, double_click, long_press, key_repeat, busy
    );

    modport slave (
        input  key_press, key_release,
        output short_press, double_click, long_press, key_repeat, busy
    );
endinterface

// File: rtl/key_timer.sv
// N-bit up-counter with synchronous clear (priority over enable).
module key_timer #(
    parameter int unsigned N = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/key_event_classifier.sv
// Turns debounced press/release pulses into short press, double click, long press
// and auto-repeat event pulses, all registered.
module key_event_classifier
    import key_pkg::*;
#(
    parameter int unsigned FREQ      = 50,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned N         = 26
) (
    input logic                   clk,
    input logic                   rst,
    key_event_classifier_if.slave bus
);

    localparam int unsigned LONG_CYC   = ms_to_cyc(LONG_MS, FREQ);
    localparam int unsigned DCLICK_CYC = ms_to_cyc(DCLICK_MS, FREQ);
    localparam int unsigned REPEAT_CYC = ms_to_cyc(REPEAT_MS, FREQ);

    key_state_e   state;
    key_state_e   state_next;
    logic [N-1:0] count;
    logic         clr;
    logic         press;
    logic         release_ev;
    logic         long_hit;
    logic         dclick_hit;
    logic         repeat_hit;
    logic         short_next;
    logic         dclick_next;
    logic         long_next;
    logic         repeat_next;

    // A press and release in the same cycle is an illegal pair and is dropped.
    assign press      = bus.key_press & ~bus.key_release;
    assign release_ev = bus.key_release & ~bus.key_press;

    assign long_hit   = (count == N'(LONG_CYC - 1));
    assign dclick_hit = (count == N'(DCLICK_CYC - 1));
    assign repeat_hit = (count == N'(REPEAT_CYC - 1));

    key_timer #(
        .N(N)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (state != StIdle),
        .count(count)
    );

    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        dclick_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        clr         = 1'b0;
        // Key edges are checked before timeouts so a coincident edge always wins.
        case (state)
            StIdle: begin
                if (press) state_next = StPress1;
            end
            StPress1: begin
                if (release_ev) begin
                    state_next = StWait2;
                end else if (long_hit) begin
                    long_next  = 1'b1;
                    state_next = StHold;
                end
            end
            StWait2: begin
                if (press) begin
                    state_next = StPress2;
                end else if (dclick_hit) begin
                    short_next = 1'b1;
                    state_next = StIdle;
                end
            end
            StPress2: begin
                if (release_ev) begin
                    dclick_next = 1'b1;
                    state_next  = StIdle;
                end
            end
            StHold: begin
                if (release_ev) begin
                    state_next = StIdle;
                end else if (repeat_hit) begin
                    repeat_next = 1'b1;
                    clr         = 1'b1;
                end
            end
            default: state_next = StIdle;
        endcase
        if (state_next != state) clr = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StIdle;
            bus.short_press  <= 1'b0;
            bus.double_click <= 1'b0;
            bus.long_press   <= 1'b0;
            bus.key_repeat   <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            state            <= state_next;
            bus.short_press  <= short_next;
            bus.double_click <= dclick_next;
            bus.long_press   <= long_next;
            bus.key_repeat   <= repeat_next;
            bus.busy         <= (state_next != StIdle);
        end
    end

endmodule
